stream_upsizer: RTL and testbench

STREAM_UPSIZER -- requirements
Module: stream_upsizer

---
 rtl/stream_upsizer.sv | 104 ++++++++++
 tb/tb_stream_upsizer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow input beats into one wide output word.
// The k-th accepted beat of a word lands in lane k, and its o_keep bit is set.
// A single output register holds each word, so latency is one cycle.
// Optional macro STREAM_UPSIZER_LAST_EN adds i_last/o_last. A beat with
// i_last set flushes a partial word early; unfilled lanes read as zero.
module stream_upsizer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic [IN_WIDTH-1:0]          i_data,
`ifdef STREAM_UPSIZER_LAST_EN
    input  logic                         i_last,
`endif
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [IN_WIDTH*RATIO-1:0]    o_data,
`ifdef STREAM_UPSIZER_LAST_EN
    output logic                         o_last,
`endif
    output logic [RATIO-1:0]             o_keep
);

    localparam int unsigned OW = IN_WIDTH * RATIO;
    localparam int unsigned LW = $clog2(RATIO);

    // Reject ratios that are not a power of two or are below two
    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $fatal(1, "stream_upsizer: RATIO must be a power of 2 and >= 2");
    end

    logic [LW-1:0] lane;
    logic [OW-1:0] acc_data;
    logic [RATIO-1:0] acc_keep;
    logic [OW-1:0] beat_data_c;
    logic [RATIO-1:0] beat_keep_c;
    logic accept_c;
    logic last_c;
    logic complete_c;

    // Output register is free, or is being drained in this same cycle
    assign i_ready  = !rst && (!o_valid || o_ready);
    assign accept_c = i_valid && i_ready;

`ifdef STREAM_UPSIZER_LAST_EN
    assign last_c = i_last;
`else
    assign last_c = 1'b0;
`endif

    assign complete_c = accept_c && ((lane == LW'(RATIO - 1)) || last_c);

    // Merge the incoming beat into its lane of the accumulator
    always_comb begin
        beat_data_c = acc_data;
        beat_keep_c = acc_keep;
        for (int k = 0; k < RATIO; k++) begin
            if (lane == LW'(k)) begin
                beat_data_c[k*IN_WIDTH +: IN_WIDTH] = i_data;
                beat_keep_c[k] = 1'b1;
            end
        end
    end

    // Accumulator, lane counter and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane     <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_keep   <= '0;
`ifdef STREAM_UPSIZER_LAST_EN
            o_last   <= 1'b0;
`endif
        end else begin
            if (complete_c) begin
                lane     <= '0;
                acc_data <= '0;
                acc_keep <= '0;
                o_valid  <= 1'b1;
                o_data   <= beat_data_c;
                o_keep   <= beat_keep_c;
`ifdef STREAM_UPSIZER_LAST_EN
                o_last   <= i_last;
`endif
            end else begin
                if (accept_c) begin
                    lane     <= lane + LW'(1);
                    acc_data <= beat_data_c;
                    acc_keep <= beat_keep_c;
                end
                if (o_ready) begin
                    o_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Testbench for stream_upsizer (IN_WIDTH=8, RATIO=4).
// A negedge monitor builds expected words from accepted beats into a queue.
// It then pops each word and compares it when the DUT hands it out.
module tb_stream_upsizer;

    localparam int unsigned W = 8;
    localparam int unsigned R = 4;

    logic clk = 1'b0;
    logic rst;
    logic i_valid;
    logic i_ready;
    logic [W-1:0] i_data;
    logic o_valid;
    logic o_ready;
    logic [W*R-1:0] o_data;
    logic [R-1:0] o_keep;
`ifdef STREAM_UPSIZER_LAST_EN
    logic i_last;
    logic o_last;
`endif

    int n_pass = 0;
    int n_total = 0;
    int out_cnt = 0;
    logic [W*R-1:0] last_out_data;

    typedef struct packed {
        logic [W*R-1:0] data;
        logic [R-1:0]   keep;
        logic           last;
    } word_t;

    word_t exp_q[$];

    // Reference packing state
    int m_lane;
    logic [W*R-1:0] m_data;
    logic [R-1:0] m_keep;

    stream_upsizer #(.IN_WIDTH(W), .RATIO(R)) dut (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_data(i_data),
`ifdef STREAM_UPSIZER_LAST_EN
        .i_last(i_last),
        .o_last(o_last),
`endif
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_data(o_data),
        .o_keep(o_keep)
    );

    always #5 clk = ~clk;

    // Scoreboard: check handshake, pop/compare outputs, model accepted beats
    always @(negedge clk) begin
        logic cur_last;
        word_t w;
        if (rst) begin
            m_lane = 0;
            m_data = '0;
            m_keep = '0;
            exp_q.delete();
        end else begin
            n_total++;
            if (i_ready !== (!o_valid || o_ready))
                $display("FAIL mon_i_ready: got %b want %b", i_ready, !o_valid || o_ready);
            else
                n_pass++;
            if (o_valid && o_ready) begin
                n_total++;
                out_cnt++;
                last_out_data = o_data;
                if (exp_q.size() == 0) begin
                    $display("FAIL mon_unexpected_word: got data %h with no word expected", o_data);
                end else begin
                    w = exp_q.pop_front();
`ifdef STREAM_UPSIZER_LAST_EN
                    if (o_data !== w.data || o_keep !== w.keep || o_last !== w.last)
                        $display("FAIL mon_word: got %h/%b/%b want %h/%b/%b",
                                 o_data, o_keep, o_last, w.data, w.keep, w.last);
                    else
                        n_pass++;
`else
                    if (o_data !== w.data || o_keep !== w.keep)
                        $display("FAIL mon_word: got %h/%b want %h/%b",
                                 o_data, o_keep, w.data, w.keep);
                    else
                        n_pass++;
`endif
                end
            end
            if (i_valid && i_ready) begin
`ifdef STREAM_UPSIZER_LAST_EN
                cur_last = i_last;
`else
                cur_last = 1'b0;
`endif
                m_data[m_lane*W +: W] = i_data;
                m_keep[m_lane] = 1'b1;
                if (m_lane == R - 1 || cur_last) begin
                    w.data = m_data;
                    w.keep = m_keep;
                    w.last = cur_last;
                    exp_q.push_back(w);
                    m_lane = 0;
                    m_data = '0;
                    m_keep = '0;
                end else begin
                    m_lane++;
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_valid = 1'b0;
        i_data  = '0;
`ifdef STREAM_UPSIZER_LAST_EN
        i_last  = 1'b0;
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1;
        o_ready = 1'b1;
        idle_inputs();
        step();
        step();
        n_total++;
        if (i_ready !== 1'b0 || o_valid !== 1'b0 || o_data !== '0 || o_keep !== '0)
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h keep=%b want 0/0/0/0",
                     i_ready, o_valid, o_data, o_keep);
        else
            n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (i_ready !== 1'b1)
            $display("FAIL reset_release_ready: got %b want 1", i_ready);
        else
            n_pass++;
        step();
    endtask

    task automatic test_basic;
        logic [W-1:0] beats [4];
        beats[0] = 8'h11;
        beats[1] = 8'h22;
        beats[2] = 8'h33;
        beats[3] = 8'h44;
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_data  = beats[i];
            step();
            if (i == 2) begin
                n_total++;
                if (o_valid !== 1'b0)
                    $display("FAIL basic_no_early_word: got o_valid=%b want 0", o_valid);
                else
                    n_pass++;
            end
        end
        idle_inputs();
        n_total++;
        if (o_valid !== 1'b1 || o_data !== 32'h44332211 || o_keep !== 4'b1111)
            $display("FAIL basic_word: got %b/%h/%b want 1/44332211/1111", o_valid, o_data, o_keep);
        else
            n_pass++;
        step();
        n_total++;
        if (o_valid !== 1'b0)
            $display("FAIL basic_drained: got o_valid=%b want 0", o_valid);
        else
            n_pass++;
    endtask

`ifdef STREAM_UPSIZER_LAST_EN
    task automatic test_last;
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hAA;
        step();
        i_data  = 8'hBB;
        i_last  = 1'b1;
        step();
        idle_inputs();
        n_total++;
        if (o_valid !== 1'b1 || o_data !== 32'h0000BBAA || o_keep !== 4'b0011 || o_last !== 1'b1)
            $display("FAIL last_flush: got %b/%h/%b/%b want 1/0000bbaa/0011/1",
                     o_valid, o_data, o_keep, o_last);
        else
            n_pass++;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_data  = W'(8'h51 + i);
            step();
        end
        idle_inputs();
        n_total++;
        if (o_data !== 32'h54535251 || o_keep !== 4'b1111 || o_last !== 1'b0)
            $display("FAIL last_next_lane0: got %h/%b/%b want 54535251/1111/0", o_data, o_keep, o_last);
        else
            n_pass++;
        step();
    endtask
`endif

    task automatic test_backpressure;
        int base;
        base = out_cnt;
        o_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_data  = W'(8'hA1 + i);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_data  = W'(8'hC1 + i);
            n_total++;
            if (i_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'hA4A3A2A1 || o_keep !== 4'b1111)
                $display("FAIL bp_hold: got rdy=%b vld=%b data=%h keep=%b want 0/1/a4a3a2a1/1111",
                         i_ready, o_valid, o_data, o_keep);
            else
                n_pass++;
            step();
        end
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_data  = W'(8'hC1 + i);
            step();
        end
        idle_inputs();
        n_total++;
        if (o_valid !== 1'b1 || o_data !== 32'hC4C3C2C1)
            $display("FAIL bp_resume: got %b/%h want 1/c4c3c2c1", o_valid, o_data);
        else
            n_pass++;
        step();
        n_total++;
        if (out_cnt - base !== 2)
            $display("FAIL bp_word_count: got %0d want 2", out_cnt - base);
        else
            n_pass++;
    endtask

    task automatic test_random;
        int idx;
        int cycles;
        int base;
        base = out_cnt;
        idx = 0;
        cycles = 0;
        while (idx < 64 && cycles < 3000) begin
            i_valid = 1'($urandom_range(0, 1));
            o_ready = 1'($urandom_range(0, 1));
            i_data  = W'($urandom);
            @(negedge clk);
            if (i_valid && i_ready) idx++;
            step();
            cycles++;
        end
        idle_inputs();
        o_ready = 1'b1;
        repeat (3) step();
        n_total++;
        if (idx !== 64 || out_cnt - base !== 16 || exp_q.size() !== 0)
            $display("FAIL random_totals: got beats=%0d words=%0d pending=%0d want 64/16/0",
                     idx, out_cnt - base, exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_back_to_back;
        int base;
        int stalls;
        base = out_cnt;
        stalls = 0;
        o_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_valid = 1'b1;
            i_data  = W'(i * 7 + 3);
            @(negedge clk);
            if (!i_ready) stalls++;
            step();
            if (i % 4 == 3) begin
                n_total++;
                if (o_valid !== 1'b1)
                    $display("FAIL b2b_word_valid: beat %0d got o_valid=%b want 1", i, o_valid);
                else
                    n_pass++;
            end
        end
        idle_inputs();
        step();
        n_total++;
        if (stalls !== 0 || out_cnt - base !== 4)
            $display("FAIL b2b_throughput: got stalls=%0d words=%0d want 0/4", stalls, out_cnt - base);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid;
        int base;
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hEE;
        step();
        i_data  = 8'hFF;
        step();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (o_valid !== 1'b0 || i_ready !== 1'b0)
            $display("FAIL midrst_state: got vld=%b rdy=%b want 0/0", o_valid, i_ready);
        else
            n_pass++;
        step();
        rst = 1'b0;
        step();
        base = out_cnt;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_data  = W'(i + 1);
            step();
        end
        idle_inputs();
        n_total++;
        if (o_valid !== 1'b1 || o_data !== 32'h04030201 || o_keep !== 4'b1111)
            $display("FAIL midrst_word: got %b/%h/%b want 1/04030201/1111", o_valid, o_data, o_keep);
        else
            n_pass++;
        step();
        step();
        n_total++;
        if (out_cnt - base !== 1 || last_out_data !== 32'h04030201)
            $display("FAIL midrst_count: got words=%0d data=%h want 1/04030201", out_cnt - base, last_out_data);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef STREAM_UPSIZER_LAST_EN
        test_last();
`endif
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid();
        n_total++;
        if (exp_q.size() !== 0)
            $display("FAIL final_queue_empty: got %0d pending want 0", exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
